// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - SAP-1 style operand capture and handshaked add/sub with result flags
module alu_operand_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             op_valid,
    input  logic             op_sub,
    input  logic             op_wb,
    output logic             op_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             ovf_flag,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             sub_q, sub_d;
    logic             wb_q, wb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             release_res;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;

    assign accept      = (state_q == S_IDLE) && op_valid;
    assign release_res = (state_q == S_HOLD) && res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (op_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_HOLD;
            S_HOLD:  if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_ready  = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            S_IDLE:  op_ready  = 1'b1;
            S_HOLD:  res_valid = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is A + ~B + 1, so the carry-in equals the sub bit.
    assign bx  = opb_q ^ {WIDTH{sub_q}};
    assign sum = {1'b0, opa_q} + {1'b0, bx} + {{WIDTH{1'b0}}, sub_q};

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sub_d    = sub_q;
        wb_d     = wb_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        // Snapshot uses pre-load register values so a same-cycle load does not leak in.
        if (accept) begin
            opa_d = a_q;
            opb_d = b_q;
            sub_d = op_sub;
            wb_d  = op_wb;
        end

        if (state_q == S_IDLE) begin
            if (load_a) a_d = bus_in;
            if (load_b) b_d = bus_in;
        end

        if (state_q == S_EXEC) begin
            result_d = sum[WIDTH-1:0];
            carry_d  = sum[WIDTH];
            zero_d   = (sum[WIDTH-1:0] == '0);
            ovf_d    = (opa_q[WIDTH-1] == bx[WIDTH-1]) &&
                       (sum[WIDTH-1] != opa_q[WIDTH-1]);
        end

        if (release_res && wb_q) begin
            a_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            sub_q    <= 1'b0;
            wb_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sub_q    <= sub_d;
            wb_q     <= wb_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result     = result_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;
    assign ovf_flag   = ovf_q;
    assign a_out      = a_q;
    assign b_out      = b_q;

endmodule
